// File: rtl/rot_boot_sequencer.sv
// rot_boot_sequencer: boot/enrollment sequencer in front of root_of_trust_top.
// Drives init and PUF requests, captures returned data, reports the outcome.
module rot_boot_sequencer #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SETTLE_CYCLES  = 5,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_enroll,
  input  logic             clear,
  input  logic [255:0]     helper_nv_in,
  input  logic             helper_nv_valid,
  output logic             system_init,
  output logic             puf_dus_enroll,
  output logic             puf_dus_regenerate,
  output logic [255:0]     puf_dus_helper_in,
  input  logic [255:0]     puf_dus_helper_out,
  input  logic             puf_dus_helper_valid,
  input  logic [127:0]     device_id,
  input  logic             device_id_valid,
  input  logic             system_ready,
  input  logic             keys_active,
  input  logic             security_fault,
  output logic [255:0]     helper_capture,
  output logic             helper_capture_valid,
  output logic [127:0]     device_id_capture,
  output logic             device_id_capture_valid,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_INIT,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] LP_TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_SET_LAST =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic             r_mode;
  logic [255:0]     r_helper_in;
  logic [255:0]     r_helper_cap;
  logic             r_helper_cap_v;
  logic [127:0]     r_id_cap;
  logic             r_id_cap_v;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_fail_code;
  logic [1:0]       w_fail_code;
  logic             w_accept;
  logic             w_in_wait;
  logic             w_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_fail_code = r_fail_code;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_fail_code = 2'd0;
          if (!mode_enroll && !helper_nv_valid) begin
            w_next      = S_FAIL;
            w_fail_code = 2'd3;
          end else if (SETTLE_CYCLES > 0) begin
            w_next = S_SETTLE;
          end else begin
            w_next = S_INIT;
          end
        end
      end
      S_SETTLE: begin
        if (security_fault) begin
          w_next      = S_FAIL;
          w_fail_code = 2'd1;
        end else if (r_cnt == LP_SET_LAST) begin
          w_next = S_INIT;
        end
      end
      S_INIT: begin
        if (security_fault) begin
          w_next      = S_FAIL;
          w_fail_code = 2'd1;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // fault beats ready, ready beats timeout
        if (security_fault) begin
          w_next      = S_FAIL;
          w_fail_code = 2'd1;
        end else if (system_ready && keys_active) begin
          w_next = S_DONE;
        end else if (r_cnt == LP_TO_LAST) begin
          w_next      = S_FAIL;
          w_fail_code = 2'd2;
        end
      end
      S_DONE, S_FAIL: begin
        if (clear) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_in_wait = (r_state == S_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept || r_state == S_INIT) begin
      r_cnt <= '0;
    end else if ((r_state == S_SETTLE && w_next == S_SETTLE) ||
                 (w_in_wait && w_next == S_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode      <= 1'b0;
      r_helper_in <= '0;
      r_fail_code <= 2'd0;
    end else begin
      r_fail_code <= w_fail_code;
      if (w_accept) begin
        r_mode      <= mode_enroll;
        r_helper_in <= mode_enroll ? '0 : helper_nv_in;
      end
    end
  end

  // captures taken on the exit edge are kept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_helper_cap   <= '0;
      r_helper_cap_v <= 1'b0;
      r_id_cap       <= '0;
      r_id_cap_v     <= 1'b0;
    end else if (w_accept) begin
      r_helper_cap   <= '0;
      r_helper_cap_v <= 1'b0;
      r_id_cap       <= '0;
      r_id_cap_v     <= 1'b0;
    end else if (w_in_wait) begin
      if (r_mode && puf_dus_helper_valid) begin
        r_helper_cap   <= puf_dus_helper_out;
        r_helper_cap_v <= 1'b1;
      end
      if (device_id_valid) begin
        r_id_cap   <= device_id;
        r_id_cap_v <= 1'b1;
      end
    end
  end

  assign w_req                   = (r_state == S_INIT) || w_in_wait;
  assign system_init             = (r_state == S_INIT);
  assign puf_dus_enroll          = w_req && r_mode;
  assign puf_dus_regenerate      = w_req && !r_mode;
  assign puf_dus_helper_in       = r_helper_in;
  assign helper_capture          = r_helper_cap;
  assign helper_capture_valid    = r_helper_cap_v;
  assign device_id_capture       = r_id_cap;
  assign device_id_capture_valid = r_id_cap_v;
  assign busy                    = (r_state == S_SETTLE) || w_req;
  assign done                    = (r_state == S_DONE);
  assign fail                    = (r_state == S_FAIL);
  assign fail_code               = r_fail_code;
  assign cycle_count             = r_cnt;

endmodule

// File: tb/tb_rot_boot_sequencer.sv
// tb_rot_boot_sequencer: scenario tasks plus random boots against
// an outcome model derived from wait-cycle event indices.
module tb_rot_boot_sequencer;

  localparam int S  = 5;
  localparam int TO = 100;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode_enroll = 1'b0;
  logic          clear = 1'b0;
  logic [255:0]  helper_nv_in = '0;
  logic          helper_nv_valid = 1'b0;
  logic          system_init;
  logic          puf_dus_enroll;
  logic          puf_dus_regenerate;
  logic [255:0]  puf_dus_helper_in;
  logic [255:0]  puf_dus_helper_out = '0;
  logic          puf_dus_helper_valid = 1'b0;
  logic [127:0]  device_id = '0;
  logic          device_id_valid = 1'b0;
  logic          system_ready = 1'b0;
  logic          keys_active = 1'b0;
  logic          security_fault = 1'b0;
  logic [255:0]  helper_capture;
  logic          helper_capture_valid;
  logic [127:0]  device_id_capture;
  logic          device_id_capture_valid;
  logic          busy;
  logic          done;
  logic          fail;
  logic [1:0]    fail_code;
  logic [CW-1:0] cycle_count;

  int errors = 0;
  int checks = 0;
  int last_cnt = 0;
  int last_code = 0;

  rot_boot_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .SETTLE_CYCLES (S),
    .CNT_W         (CW)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .mode_enroll            (mode_enroll),
    .clear                  (clear),
    .helper_nv_in           (helper_nv_in),
    .helper_nv_valid        (helper_nv_valid),
    .system_init            (system_init),
    .puf_dus_enroll         (puf_dus_enroll),
    .puf_dus_regenerate     (puf_dus_regenerate),
    .puf_dus_helper_in      (puf_dus_helper_in),
    .puf_dus_helper_out     (puf_dus_helper_out),
    .puf_dus_helper_valid   (puf_dus_helper_valid),
    .device_id              (device_id),
    .device_id_valid        (device_id_valid),
    .system_ready           (system_ready),
    .keys_active            (keys_active),
    .security_fault         (security_fault),
    .helper_capture         (helper_capture),
    .helper_capture_valid   (helper_capture_valid),
    .device_id_capture      (device_id_capture),
    .device_id_capture_valid(device_id_capture_valid),
    .busy                   (busy),
    .done                   (done),
    .fail                   (fail),
    .fail_code              (fail_code),
    .cycle_count            (cycle_count)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs;
    system_ready         = 1'b0;
    keys_active          = 1'b0;
    security_fault       = 1'b0;
    puf_dus_helper_valid = 1'b0;
    device_id_valid      = 1'b0;
  endtask

  // One boot; event args are wait-cycle indices, negative = never.
  task automatic run_boot(
    input bit en, input bit nvv, input logic [255:0] nv,
    input int rdy_k, input int flt_k, input int hv1_k,
    input int hv2_k, input int id_k,
    input logic [255:0] hv1_d, input logic [255:0] hv2_d,
    input logic [127:0] id_d);
    int kend, code, n, k, last;
    bit dn, hcv, idv, miss, exp_on;
    logic [255:0] hc;
    logic [127:0] ic;
    miss = !en && !nvv;
    kend = TO - 1;
    code = 2;
    dn   = 1'b0;
    if (flt_k >= 0 && flt_k <= kend) begin
      kend = flt_k;
      code = 1;
    end
    if (rdy_k >= 0 && (rdy_k < kend || (rdy_k == kend && code == 2))) begin
      kend = rdy_k;
      code = 0;
      dn   = 1'b1;
    end
    hcv = 1'b0;
    hc  = '0;
    if (en && hv1_k >= 0 && hv1_k <= kend) begin
      hcv = 1'b1;
      hc  = hv1_d;
    end
    if (en && hv2_k >= 0 && hv2_k <= kend) begin
      hcv = 1'b1;
      hc  = hv2_d;
    end
    idv = (id_k >= 0 && id_k <= kend);
    ic  = idv ? id_d : '0;
    if (miss) begin
      kend = 0;
      code = 3;
      dn   = 1'b0;
      hcv  = 1'b0;
      hc   = '0;
      idv  = 1'b0;
      ic   = '0;
    end
    @(negedge clock);
    start           = 1'b1;
    mode_enroll     = en;
    helper_nv_in    = nv;
    helper_nv_valid = nvv;
    @(posedge clock);
    #1 start = 1'b0;
    n = 1;
    last = miss ? 0 : S + 2 + kend;
    while (n <= last) begin
      k = n - (S + 2);
      security_fault = (k >= 0 && k == flt_k);
      if (k >= 0 && k == rdy_k) begin
        system_ready = 1'b1;
        keys_active  = 1'b1;
      end else begin
        system_ready = 1'($urandom_range(0, 1));
        keys_active  = system_ready ? 1'b0 : 1'($urandom_range(0, 1));
      end
      puf_dus_helper_valid = (k >= 0 && (k == hv1_k || k == hv2_k));
      if (k >= 0 && k == hv1_k)      puf_dus_helper_out = hv1_d;
      else if (k >= 0 && k == hv2_k) puf_dus_helper_out = hv2_d;
      else puf_dus_helper_out = {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom};
      device_id_valid = (k >= 0 && k == id_k);
      device_id = (k >= 0 && k == id_k) ? id_d :
                  {$urandom, $urandom, $urandom, $urandom};
      @(negedge clock);
      exp_on = (n >= S + 1);
      checks++;
      if (system_init !== (n == S + 1)) begin
        errors++;
        $display("FAIL init_timing: cycle %0d got %b want %b",
                 n, system_init, (n == S + 1));
      end
      checks++;
      if ({busy, done, fail} !== 3'b100) begin
        errors++;
        $display("FAIL busy_phase: cycle %0d got b/d/f=%b want 100",
                 n, {busy, done, fail});
      end
      checks++;
      if ({puf_dus_enroll, puf_dus_regenerate} !==
          {en && exp_on, !en && exp_on}) begin
        errors++;
        $display("FAIL mode_req: cycle %0d got %b want %b", n,
                 {puf_dus_enroll, puf_dus_regenerate},
                 {en && exp_on, !en && exp_on});
      end
      @(posedge clock);
      #1 n++;
    end
    idle_inputs();
    @(negedge clock);
    checks++;
    if ({done, fail} !== {dn, !dn}) begin
      errors++;
      $display("FAIL outcome: got d/f=%b want %b", {done, fail}, {dn, !dn});
    end
    checks++;
    if (fail_code !== 2'(code)) begin
      errors++;
      $display("FAIL fail_code: got %0d want %0d", fail_code, code);
    end
    checks++;
    if (cycle_count !== CW'(kend)) begin
      errors++;
      $display("FAIL cycle_count: got %0d want %0d", cycle_count, kend);
    end
    checks++;
    if ({system_init, puf_dus_enroll, puf_dus_regenerate, busy} !== 4'b0) begin
      errors++;
      $display("FAIL ctrl_after: got %b want 0000",
               {system_init, puf_dus_enroll, puf_dus_regenerate, busy});
    end
    checks++;
    if (helper_capture_valid !== hcv || helper_capture !== hc) begin
      errors++;
      $display("FAIL helper_cap: got %b/%h want %b/%h",
               helper_capture_valid, helper_capture, hcv, hc);
    end
    checks++;
    if (device_id_capture_valid !== idv || device_id_capture !== ic) begin
      errors++;
      $display("FAIL id_cap: got %b/%h want %b/%h",
               device_id_capture_valid, device_id_capture, idv, ic);
    end
    checks++;
    if (puf_dus_helper_in !== (en ? 256'd0 : nv)) begin
      errors++;
      $display("FAIL helper_in: got %h want %h",
               puf_dus_helper_in, (en ? 256'd0 : nv));
    end
    last_cnt  = kend;
    last_code = code;
  endtask

  task automatic do_clear;
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    checks++;
    if ({system_init, puf_dus_enroll, puf_dus_regenerate,
         busy, done, fail} !== 6'b0) begin
      errors++;
      $display("FAIL clear_idle: got %b want 000000",
               {system_init, puf_dus_enroll, puf_dus_regenerate,
                busy, done, fail});
    end
    checks++;
    if (cycle_count !== CW'(last_cnt) || fail_code !== 2'(last_code)) begin
      errors++;
      $display("FAIL clear_keep: got cnt=%0d code=%0d want %0d/%0d",
               cycle_count, fail_code, last_cnt, last_code);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({system_init, puf_dus_enroll, puf_dus_regenerate, busy, done, fail,
         fail_code, helper_capture_valid, device_id_capture_valid,
         cycle_count, helper_capture, device_id_capture,
         puf_dus_helper_in} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (init=%b busy=%b)",
               system_init, busy);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, done, fail} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 000", {busy, done, fail});
    end
  endtask

  task automatic test_enroll;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    run_boot(1'b1, 1'b0, '0, 40, -1, 20, -1, 30,
             a5, '0, 128'h1234);
    do_clear();
  endtask

  task automatic test_regenerate;
    logic [255:0] v5a;
    v5a = {32{8'h5A}};
    run_boot(1'b0, 1'b1, v5a, 25, -1, 5, -1, 7,
             {32{8'hC3}}, '0, 128'hBEEF_0001);
    do_clear();
  endtask

  task automatic test_missing_helper;
    run_boot(1'b0, 1'b0, {32{8'h11}}, 3, -1, -1, -1, -1, '0, '0, '0);
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (system_init !== 1'b0 || fail !== 1'b1) begin
        errors++;
        $display("FAIL missing_hold: got init=%b fail=%b want 0/1",
                 system_init, fail);
      end
    end
    do_clear();
  endtask

  task automatic test_timeout;
    run_boot(1'b1, 1'b1, '0, -1, -1, 50, -1, -1,
             {8{32'hDEAD_BEEF}}, '0, '0);
    do_clear();
  endtask

  task automatic test_fault_ready;
    run_boot(1'b1, 1'b0, '0, 10, 10, 10, -1, 10,
             {8{32'h0F0F_1234}}, '0, 128'h77);
    do_clear();
  endtask

  task automatic test_ready_at_timeout;
    run_boot(1'b0, 1'b1, {8{32'h1357_9BDF}}, TO - 1, -1, -1, -1, TO - 1,
             '0, '0, 128'hABCD);
    do_clear();
  endtask

  task automatic test_start_ignored;
    run_boot(1'b0, 1'b1, {8{32'h2468_ACE0}}, 4, -1, -1, -1, -1,
             '0, '0, '0);
    @(negedge clock);
    start       = 1'b1;
    mode_enroll = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cycle_count !== CW'(4)) begin
      errors++;
      $display("FAIL start_in_done: got d=%b b=%b cnt=%0d want 1/0/4",
               done, busy, cycle_count);
    end
    do_clear();
  endtask

  task automatic test_clear_start;
    run_boot(1'b1, 1'b0, '0, 2, -1, 1, -1, -1,
             {8{32'h5555_AAAA}}, '0, '0);
    @(negedge clock);
    clear       = 1'b1;
    start       = 1'b1;
    mode_enroll = 1'b1;
    @(posedge clock);
    #1 begin
      clear = 1'b0;
      start = 1'b0;
    end
    repeat (2) begin
      @(negedge clock);
      checks++;
      if ({busy, done, fail} !== 3'b000 || cycle_count !== CW'(2)) begin
        errors++;
        $display("FAIL clear_wins: got b/d/f=%b cnt=%0d want 000/2",
                 {busy, done, fail}, cycle_count);
      end
    end
  endtask

  task automatic test_random;
    bit en, nvv;
    int rdy, flt, h1, h2, id;
    for (int i = 0; i < 10; i++) begin
      en  = 1'($urandom_range(0, 1));
      nvv = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 120));
      flt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 120)) : -1;
      h1  = int'($urandom_range(0, 60));
      h2  = h1 + int'($urandom_range(1, 60));
      id  = int'($urandom_range(0, 99));
      run_boot(en, nvv,
               {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom},
               rdy, flt, h1, h2, id,
               {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom});
      do_clear();
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    start           = 1'b1;
    mode_enroll     = 1'b1;
    helper_nv_valid = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (S + 1) @(posedge clock);
    #1 begin
      device_id_valid = 1'b1;
      device_id       = 128'h99;
    end
    @(posedge clock);
    #1 device_id_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (puf_dus_enroll !== 1'b1 || device_id_capture_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_wait: got enr=%b idv=%b want 1/1",
               puf_dus_enroll, device_id_capture_valid);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({system_init, puf_dus_enroll, puf_dus_regenerate, busy, done, fail,
         fail_code, helper_capture_valid, device_id_capture_valid,
         cycle_count, helper_capture, device_id_capture,
         puf_dus_helper_in} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got enr=%b busy=%b idv=%b want zeros",
               puf_dus_enroll, busy, device_id_capture_valid);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_boot(1'b1, 1'b1, '0, 12, -1, 3, 9, 6,
             {8{32'h1111_2222}}, {8{32'h3333_4444}}, 128'h42);
    do_clear();
  endtask

  initial begin
    test_reset();
    test_enroll();
    test_regenerate();
    test_missing_helper();
    test_timeout();
    test_fault_ready();
    test_ready_at_timeout();
    test_start_ignored();
    test_clear_start();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
